// File: rtl/fido_trip_logger.sv
// ============================================================================
// Module   : fido_trip_logger
// Brief    : Logs location changes from the navigation FSM into a FWFT
//            history FIFO, counts steps and flags arrival at a target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fido_trip_logger #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [2:0]                 LOC_IN,
    input  logic [2:0]                 TARGET,
    input  logic                       START,
    input  logic                       RD_EN,
    output logic [2:0]                 RD_DATA,
    output logic                       EMPTY,
    output logic                       FULL,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic [CNT_W-1:0]           STEPS,
    output logic                       BUSY,
    output logic                       ARRIVED,
    output logic                       OVERFLOW
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [AW:0]      C_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]      C_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]    C_PSTEP = AW'(1);
    localparam logic [CNT_W-1:0] C_SMAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_SONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_prev_loc;
    logic [2:0]      r_tgt;
    logic [CNT_W-1:0] r_steps;
    logic            r_overflow;
    logic [2:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_change;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;

    assign w_full   = (r_count == C_FULL);
    assign w_empty  = (r_count == '0);
    // START always wins over change detection, so a restart cycle logs nothing
    assign w_change = (r_state == S_TRACK) && !START && (LOC_IN != r_prev_loc);
    assign w_pop    = RD_EN && !w_empty;
    assign w_push   = w_change && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (START) begin
            w_state_nxt = (LOC_IN == TARGET) ? S_DONE : S_TRACK;
        end else begin
            case (r_state)
                S_TRACK: if (w_change && (LOC_IN == r_tgt)) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_prev_loc <= 3'd0;
            r_tgt      <= 3'd0;
            r_steps    <= '0;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (START) begin
                r_tgt      <= TARGET;
                r_prev_loc <= LOC_IN;
                r_steps    <= '0;
            end else if (w_change) begin
                r_prev_loc <= LOC_IN;
                if (r_steps != C_SMAX) r_steps <= r_steps + C_SONE;
            end

            if (w_change && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + C_PSTEP;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PSTEP;

            if (w_push && !w_pop)      r_count <= r_count + C_ONE;
            else if (w_pop && !w_push) r_count <= r_count - C_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push && !RESET) r_mem[r_wr_ptr] <= LOC_IN;
    end

    assign RD_DATA  = w_empty ? 3'd0 : r_mem[r_rd_ptr];
    assign EMPTY    = w_empty;
    assign FULL     = w_full;
    assign COUNT    = r_count;
    assign STEPS    = r_steps;
    assign BUSY     = (r_state == S_TRACK);
    assign ARRIVED  = (r_state == S_DONE);
    assign OVERFLOW = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fido_trip_logger.sv
// ============================================================================
// Module   : tb_fido_trip_logger
// Brief    : Directed self-checking bench for fido_trip_logger (DEPTH=8 with
//            CNT_W=8, plus a CNT_W=2 instance sharing the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fido_trip_logger;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] loc_in;
    logic [2:0] target;
    logic       start;
    logic       rd_en;

    logic [2:0] rd_data,  rd_data2;
    logic       empty,    empty2;
    logic       full,     full2;
    logic [3:0] count,    count2;
    logic [7:0] steps;
    logic [1:0] steps2;
    logic       busy,     busy2;
    logic       arrived,  arrived2;
    logic       overflow, overflow2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fido_trip_logger #(.DEPTH(8), .CNT_W(8)) u_dut (
        .CLK(clk), .RESET(rst), .LOC_IN(loc_in), .TARGET(target),
        .START(start), .RD_EN(rd_en), .RD_DATA(rd_data), .EMPTY(empty),
        .FULL(full), .COUNT(count), .STEPS(steps), .BUSY(busy),
        .ARRIVED(arrived), .OVERFLOW(overflow)
    );

    fido_trip_logger #(.DEPTH(8), .CNT_W(2)) u_dut_sat (
        .CLK(clk), .RESET(rst), .LOC_IN(loc_in), .TARGET(target),
        .START(start), .RD_EN(rd_en), .RD_DATA(rd_data2), .EMPTY(empty2),
        .FULL(full2), .COUNT(count2), .STEPS(steps2), .BUSY(busy2),
        .ARRIVED(arrived2), .OVERFLOW(overflow2)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so checks see post-edge register values
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " EMPTY"},    int'(empty),    1);
        check_val({tag, " FULL"},     int'(full),     0);
        check_val({tag, " COUNT"},    int'(count),    0);
        check_val({tag, " STEPS"},    int'(steps),    0);
        check_val({tag, " BUSY"},     int'(busy),     0);
        check_val({tag, " ARRIVED"},  int'(arrived),  0);
        check_val({tag, " OVERFLOW"}, int'(overflow), 0);
        check_val({tag, " RD_DATA"},  int'(rd_data),  0);
        check_val({tag, " STEPS2"},   int'(steps2),   0);
    endtask

    initial begin
        rst = 1'b1; loc_in = 3'd0; target = 3'd0; start = 1'b0; rd_en = 1'b0;
        #2;
        tick(); tick();
        check_reset_state("reset");

        // idle with moving location: nothing logged
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            loc_in = 3'(i);
            tick();
        end
        check_val("idle EMPTY", int'(empty), 1);
        check_val("idle STEPS", int'(steps), 0);
        check_val("idle BUSY",  int'(busy),  0);

        // trip 0 -> 1 -> 4 -> 7 with target 7
        loc_in = 3'd0; target = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("trip BUSY after start", int'(busy), 1);
        loc_in = 3'd1; tick(); tick();
        loc_in = 3'd4; tick(); tick();
        check_val("trip ARRIVED before 7", int'(arrived), 0);
        loc_in = 3'd7; tick();
        check_val("trip ARRIVED", int'(arrived), 1);
        check_val("trip BUSY",    int'(busy),    0);
        check_val("trip STEPS",   int'(steps),   3);
        check_val("trip STEPS2",  int'(steps2),  3);
        check_val("trip COUNT",   int'(count),   3);

        // start already at target; FIFO untouched
        loc_in = 3'd3; target = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("attgt ARRIVED", int'(arrived), 1);
        check_val("attgt STEPS",   int'(steps),   0);
        check_val("attgt COUNT",   int'(count),   3);
        loc_in = 3'd5; tick();
        check_val("done ignores COUNT", int'(count), 3);
        check_val("done ignores STEPS", int'(steps), 0);

        // drain history in order
        check_val("pop head0", int'(rd_data), 1);
        rd_en = 1'b1; tick();
        check_val("pop head1", int'(rd_data), 4);
        tick();
        check_val("pop head2", int'(rd_data), 7);
        tick();
        rd_en = 1'b0;
        check_val("pop EMPTY", int'(empty), 1);

        // overflow: 9 changes into an 8-deep FIFO
        loc_in = 3'd2; target = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            loc_in = (i % 2 == 0) ? 3'd1 : 3'd2;
            tick();
            if (i == 7) begin
                check_val("ovf at 8 COUNT",    int'(count),    8);
                check_val("ovf at 8 OVERFLOW", int'(overflow), 0);
            end
        end
        check_val("ovf COUNT",    int'(count),    8);
        check_val("ovf FULL",     int'(full),     1);
        check_val("ovf OVERFLOW", int'(overflow), 1);
        check_val("ovf STEPS",    int'(steps),    9);
        check_val("ovf STEPS2",   int'(steps2),   3);
        check_val("ovf head",     int'(rd_data),  1);

        // simultaneous pop and push while full
        loc_in = 3'd2; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_val("fullpp COUNT",    int'(count),    8);
        check_val("fullpp OVERFLOW", int'(overflow), 1);
        check_val("fullpp head",     int'(rd_data),  2);
        check_val("fullpp STEPS",    int'(steps),    10);

        // drain to one entry, then over-read
        rd_en = 1'b1;
        repeat (7) tick();
        rd_en = 1'b0;
        check_val("one COUNT", int'(count),   1);
        check_val("one head",  int'(rd_data), 2);
        rd_en = 1'b1;
        repeat (3) tick();
        check_val("under EMPTY",   int'(empty),   1);
        check_val("under COUNT",   int'(count),   0);
        check_val("under RD_DATA", int'(rd_data), 0);

        // push and pop together while empty
        loc_in = 3'd5;
        tick();
        rd_en = 1'b0;
        check_val("emptypp COUNT", int'(count),   1);
        check_val("emptypp head",  int'(rd_data), 5);

        // restart during a change: change dropped, target relatched
        loc_in = 3'd6; target = 3'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("restart COUNT",    int'(count),    1);
        check_val("restart STEPS",    int'(steps),    0);
        check_val("restart BUSY",     int'(busy),     1);
        check_val("restart OVERFLOW", int'(overflow), 1);
        target = 3'd7; loc_in = 3'd4;
        tick();
        check_val("relatch ARRIVED", int'(arrived), 1);
        check_val("relatch STEPS",   int'(steps),   1);
        check_val("relatch COUNT",   int'(count),   2);

        // reset mid-trip with FIFO occupied
        loc_in = 3'd4; target = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        loc_in = 3'd1;
        tick();
        check_val("pre-reset COUNT", int'(count), 3);
        rst = 1'b1; start = 1'b1; rd_en = 1'b1;
        tick();
        check_reset_state("midreset");
        rst = 1'b0; start = 1'b0; rd_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
